// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions used by the fetch stage: state encoding,
// opcode constants and default datapath widths.
package fetch_unit_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int IMM_BIT_DEF = 0;

  // Opcodes live in the top five bits of the instruction word.
  localparam int              OPC_W   = 5;
  localparam logic [OPC_W-1:0] OPC_HLT = 5'b00001;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_FETCH_IMM,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter: synchronous reset, load, increment or hold, with the
// incremented value also exported so the fetch stage can report it.
module fetch_unit_pc_register
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  // Modulo 2^ADDR_W: the all-ones address wraps silently to zero.
  assign pc_plus1 = pc + ADDR_W'(1);

  // PC update: reset beats load, load beats increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc_plus1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: boots the PC from memory, assembles optional
// two-word instructions, honours redirect/stall and freezes on HLT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               WIDTH      = WIDTH_DEF,
  parameter int               ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0,
  parameter int               IMM_BIT    = IMM_BIT_DEF,
  parameter logic [OPC_W-1:0] HLT_OPCODE = OPC_HLT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WIDTH-1:0]  imem_data,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [WIDTH-1:0]  instr_out,
  output logic [WIDTH-1:0]  imm_out,
  output logic [ADDR_W-1:0] pc_next_out,
  output logic              valid_out,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_plus1;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc_load_val;

  // First word of a two-word instruction, held while the immediate is read.
  logic [WIDTH-1:0]  instr_lat_p0, instr_lat_d;

  logic [WIDTH-1:0]  instr_d, imm_d;
  logic [ADDR_W-1:0] pc_next_d;
  logic              valid_d, halted_d;
  logic              is_imm, is_hlt;

  assign is_imm = imem_data[IMM_BIT];
  assign is_hlt = (imem_data[WIDTH-1 -: OPC_W] == HLT_OPCODE);

  fetch_unit_pc_register #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc_q),
    .pc_plus1 (pc_plus1)
  );

  // Next-state, PC control and next output values; anything not written
  // below holds, which is what a stall relies on.
  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    pc_load_val = redirect_pc;
    pc_inc      = 1'b0;
    instr_lat_d = instr_lat_p0;
    instr_d     = instr_out;
    imm_d       = imm_out;
    pc_next_d   = pc_next_out;
    valid_d     = valid_out;
    halted_d    = halted;
    imem_addr   = pc_q;

    case (state_q)
      ST_BOOT: begin
        imem_addr   = BOOT_ADDR;
        pc_load     = 1'b1;
        pc_load_val = ADDR_W'(imem_data);
        valid_d     = 1'b0;
        state_d     = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect_en) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_inc      = 1'b1;
          instr_lat_d = imem_data;
          if (is_imm) begin
            valid_d = 1'b0;
            state_d = ST_FETCH_IMM;
          end else begin
            instr_d   = imem_data;
            imm_d     = '0;
            pc_next_d = pc_plus1;
            valid_d   = 1'b1;
            if (is_hlt) begin
              state_d = ST_HALTED;
            end
          end
        end
      end

      ST_FETCH_IMM: begin
        if (redirect_en) begin
          // Drops the half-assembled instruction.
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end else if (!stall) begin
          pc_inc    = 1'b1;
          instr_d   = instr_lat_p0;
          imm_d     = imem_data;
          pc_next_d = pc_plus1;
          valid_d   = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_HALTED: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, latch and registered outputs; reset clears all of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      instr_lat_p0 <= '0;
      instr_out    <= '0;
      imm_out      <= '0;
      pc_next_out  <= '0;
      valid_out    <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_lat_p0 <= instr_lat_d;
      instr_out    <= instr_d;
      imm_out      <= imm_d;
      pc_next_out  <= pc_next_d;
      valid_out    <= valid_d;
      halted       <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed per-cycle vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_en;
  logic [15:0] redirect_pc, imem_addr, imem_data;
  logic [15:0] instr_out, imm_out, pc_next_out;
  logic        valid_out, halted;

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .imm_out     (imm_out),
    .pc_next_out (pc_next_out),
    .valid_out   (valid_out),
    .halted      (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] ei, input logic [15:0] em,
                          input logic [15:0] ep, input logic ev, input logic eh);
    chk({tag, ".instr"},  {16'h0, instr_out},   {16'h0, ei});
    chk({tag, ".imm"},    {16'h0, imm_out},     {16'h0, em});
    chk({tag, ".pcnext"}, {16'h0, pc_next_out}, {16'h0, ep});
    chk({tag, ".valid"},  {31'h0, valid_out},   {31'h0, ev});
    chk({tag, ".halted"}, {31'h0, halted},      {31'h0, eh});
  endtask

  // Directed vectors: inputs for one cycle, imem_addr seen before the edge,
  // registered outputs expected after it.
  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] pcn;
    logic        valid;
    logic        halted;
  } vec_t;

  vec_t tbl [15];

  // Behavioural reference: fetch pointer, pending first word, halt flag.
  logic        m_boot, m_pend, m_halt;
  logic [15:0] m_pc, m_word;
  logic [15:0] m_instr, m_imm, m_pcn;
  logic        m_valid, m_halted;

  task automatic model_step(input logic r, input logic s, input logic rd, input logic [15:0] rp);
    logic [15:0] w;
    if (r) begin
      m_boot = 1; m_pend = 0; m_halt = 0; m_pc = 0; m_word = 0;
      m_instr = 0; m_imm = 0; m_pcn = 0; m_valid = 0; m_halted = 0;
    end else if (m_boot) begin
      m_pc = mem[0]; m_boot = 0; m_valid = 0;
    end else if (m_halt) begin
      m_valid = 0; m_halted = 1;
    end else if (rd) begin
      m_pc = rp; m_pend = 0; m_valid = 0;
    end else if (s) begin
      // everything holds
    end else if (m_pend) begin
      m_instr = m_word; m_imm = mem[m_pc]; m_pcn = m_pc + 16'd1;
      m_valid = 1; m_pc = m_pc + 16'd1; m_pend = 0;
    end else begin
      w = mem[m_pc];
      if (w[0]) begin
        m_word = w; m_pend = 1; m_valid = 0;
      end else begin
        m_instr = w; m_imm = 0; m_pcn = m_pc + 16'd1; m_valid = 1;
        if (w[15:11] == 5'b00001) m_halt = 1;
      end
      m_pc = m_pc + 16'd1;
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
    mem[16'h0000] = 16'h0010;
    mem[16'h0010] = 16'h1234;
    mem[16'h0011] = 16'h2001;
    mem[16'h0012] = 16'hBEEF;
    mem[16'h0013] = 16'h3000;
    mem[16'h0014] = 16'h4002;
    mem[16'h0015] = 16'h2001;
    mem[16'h0016] = 16'hCAFE;
    mem[16'h0040] = 16'h0800;
    mem[16'hFFFF] = 16'h5000;

    //            stall redir rpc      addr     instr    imm      pcn      v  h
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0010, 16'h1234, 16'h0000, 16'h0011, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0011, 16'h1234, 16'h0000, 16'h0011, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0012, 16'h2001, 16'hBEEF, 16'h0013, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0013, 16'h2001, 16'hBEEF, 16'h0013, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0013, 16'h2001, 16'hBEEF, 16'h0013, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0013, 16'h2001, 16'hBEEF, 16'h0013, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0013, 16'h3000, 16'h0000, 16'h0014, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0014, 16'h4002, 16'h0000, 16'h0015, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0015, 16'h4002, 16'h0000, 16'h0015, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 16'h0040, 16'h0016, 16'h4002, 16'h0000, 16'h0015, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h0040, 16'h0800, 16'h0000, 16'h0041, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 16'h0010, 16'h0041, 16'h0800, 16'h0000, 16'h0041, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 16'h0010, 16'h0041, 16'h0800, 16'h0000, 16'h0041, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 16'h0041, 16'h0800, 16'h0000, 16'h0041, 1'b0, 1'b1};

    // Reset state
    tick(); tick();
    chk_outs("reset", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    reset = 1'b0;

    // Directed table: boot, two-word, stall, redirect in FETCH_IMM, HLT
    for (int i = 0; i < 15; i++) begin
      stall = tbl[i].stall; redirect_en = tbl[i].redir; redirect_pc = tbl[i].rpc;
      chk($sformatf("tbl%0d.addr", i), {16'h0, imem_addr}, {16'h0, tbl[i].addr});
      tick();
      chk_outs($sformatf("tbl%0d", i), tbl[i].instr, tbl[i].imm, tbl[i].pcn,
               tbl[i].valid, tbl[i].halted);
    end
    stall = 1'b0; redirect_en = 1'b0;

    // Reset out of HALTED restarts BOOT
    reset = 1'b1;
    tick();
    chk_outs("hltrst", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("hltrst.addr", {16'h0, imem_addr}, 32'h0);
    tick();
    chk("boot.addr", {16'h0, imem_addr}, 32'h10);

    // Wrap: redirect to 0xFFFF, single-word there
    redirect_en = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_en = 1'b0;
    chk("wrap.vld0", {31'h0, valid_out}, 32'h0);
    chk("wrap.addr", {16'h0, imem_addr}, 32'hFFFF);
    tick();
    chk_outs("wrap", 16'h5000, 16'h0, 16'h0000, 1'b1, 1'b0);
    chk("wrap.next", {16'h0, imem_addr}, 32'h0);

    // Randomized run against the reference model
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    for (int i = 0; i < 4000; i++) begin
      logic r, s, rd;
      logic [15:0] rp;
      r  = (i < 2) || ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      rp = 16'($urandom);
      reset = r; stall = s; redirect_en = rd; redirect_pc = rp;
      if (i > 0)
        chk("rnd.addr", {16'h0, imem_addr}, {16'h0, (m_boot ? 16'h0 : m_pc)});
      model_step(r, s, rd, rp);
      tick();
      chk_outs("rnd", m_instr, m_imm, m_pcn, m_valid, m_halted);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
